// File: rtl/nucleo_pkg.sv
// nucleo_pkg: shared definitions for the multicycle core.
//   - opcode constants OP_ADD .. OP_LI (13..15 are illegal)
//   - FSM state enum (IDLE, DEC, EXE, WB)
//   - instruction field extractors; the register-address width is passed as
//     an argument so one helper serves every NUM_REGS (up to MAX_AW bits).
package nucleo_pkg;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_SLT  = 4'd5;
   localparam logic [3:0] OP_ADDI = 4'd6;
   localparam logic [3:0] OP_SUBI = 4'd7;
   localparam logic [3:0] OP_ANDI = 4'd8;
   localparam logic [3:0] OP_ORI  = 4'd9;
   localparam logic [3:0] OP_SHLI = 4'd10;
   localparam logic [3:0] OP_SHRI = 4'd11;
   localparam logic [3:0] OP_LI   = 4'd12;

   typedef enum logic [1:0] {IDLE, DEC, EXE, WB} state_t;

   // Widest supported register address and instruction.
   localparam int MAX_AW = 8;
   localparam int MAX_IW = 4 + 3 * MAX_AW;

   // Opcode sits directly above the three register fields.
   function automatic logic [3:0] get_op(input logic [MAX_IW-1:0] ins, input int aw);
      logic [MAX_IW-1:0] s;
      s = ins >> (3 * aw);
      return s[3:0];
   endfunction

   // idx: 0 = rb, 1 = ra, 2 = rc (LSB upward).
   function automatic logic [MAX_AW-1:0] get_field(input logic [MAX_IW-1:0] ins,
                                                   input int aw, input int idx);
      logic [MAX_IW-1:0] s;
      logic [MAX_AW-1:0] m;
      s = ins >> (idx * aw);
      m = ~({MAX_AW{1'b1}} << aw);
      return s[MAX_AW-1:0] & m;
   endfunction

endpackage

// File: rtl/banco_regs_param.sv
// banco_regs_param: NUM_REGS x DATA_W register file, R0 reads as zero.
//   clk, rst                : clock, async active-high reset (clears all)
//   rd_addr_a/b, rd_data_a/b: combinational reads, registered by the caller
//   dbg_addr, dbg_data      : combinational debug read
//   we, wr_addr, wr_data    : synchronous write port (writes to R0 dropped)
module banco_regs_param #(
   parameter int DATA_W   = 16,
   parameter int NUM_REGS = 16,
   parameter int ADDR_W   = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] rd_addr_a,
   output logic [DATA_W-1:0] rd_data_a,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic [DATA_W-1:0] rd_data_b,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data,
   input  logic              we,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data
);

   logic [DATA_W-1:0] regs [NUM_REGS];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (we && (wr_addr != '0)) begin
         regs[wr_addr] <= wr_data;
      end
   end

   // R0 is also masked on read so it is zero regardless of storage.
   assign rd_data_a = (rd_addr_a == '0) ? '0 : regs[rd_addr_a];
   assign rd_data_b = (rd_addr_b == '0) ? '0 : regs[rd_addr_b];
   assign dbg_data  = (dbg_addr  == '0) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/nucleo_multiciclo.sv
// nucleo_multiciclo: four-state multicycle core (IDLE/accept, DEC, EXE, WB).
//   clk, rst                 : clock, async active-high reset
//   instr_valid/instr_ready  : instruction handshake, ready only in IDLE
//   instr                    : {op[3:0], rc, ra, rb}
//   result, result_valid     : written-back value (held) and its WB pulse
//   illegal                  : WB pulse for opcodes 13..15
//   flag_zero, flag_carry    : flags of the last legal instruction
//   busy                     : not in IDLE
//   dbg_addr, dbg_data       : combinational register peek
module nucleo_multiciclo
   import nucleo_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int NUM_REGS   = 16,
   parameter int REG_ADDR_W = $clog2(NUM_REGS),
   parameter int INSTR_W    = 4 + 3 * REG_ADDR_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  instr_valid,
   output logic                  instr_ready,
   input  logic [INSTR_W-1:0]    instr,
   output logic [DATA_W-1:0]     result,
   output logic                  result_valid,
   output logic                  illegal,
   output logic                  flag_zero,
   output logic                  flag_carry,
   output logic                  busy,
   input  logic [REG_ADDR_W-1:0] dbg_addr,
   output logic [DATA_W-1:0]     dbg_data
);

   state_t state_q, state_d;

   logic [INSTR_W-1:0]    instr_q;
   logic [MAX_IW-1:0]     ins_ext;
   logic [3:0]            op;
   logic [REG_ADDR_W-1:0] rc_f, ra_f, rb_f;
   logic [DATA_W-1:0]     rd_a, rd_b, opa_q, opb_q;
   logic [DATA_W-1:0]     alu_y, alu_q, imm;
   logic                  alu_c, carry_q, ill, ill_q, slt;
   int                    shamt;

   assign ins_ext = MAX_IW'(instr_q);
   assign op      = get_op(ins_ext, REG_ADDR_W);
   assign rc_f    = REG_ADDR_W'(get_field(ins_ext, REG_ADDR_W, 2));
   assign ra_f    = REG_ADDR_W'(get_field(ins_ext, REG_ADDR_W, 1));
   assign rb_f    = REG_ADDR_W'(get_field(ins_ext, REG_ADDR_W, 0));
   assign ill     = (op > OP_LI);

   banco_regs_param #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(REG_ADDR_W)) u_regs (
      .clk       (clk),
      .rst       (rst),
      .rd_addr_a (ra_f),
      .rd_data_a (rd_a),
      .rd_addr_b (rb_f),
      .rd_data_b (rd_b),
      .dbg_addr  (dbg_addr),
      .dbg_data  (dbg_data),
      .we        ((state_q == WB) && !ill_q),
      .wr_addr   (rc_f),
      .wr_data   (alu_q)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d      = state_q;
      instr_ready  = 1'b0;
      busy         = 1'b1;
      result_valid = 1'b0;
      illegal      = 1'b0;
      case (state_q)
         IDLE: begin
            instr_ready = 1'b1;
            busy        = 1'b0;
            if (instr_valid) state_d = DEC;
         end
         DEC: state_d = EXE;
         EXE: state_d = WB;
         WB: begin
            result_valid = 1'b1;
            illegal      = ill_q;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // ALU on the registered operands; immediates come from the ra field.
   always_comb begin
      alu_y = '0;
      alu_c = 1'b0;
      imm   = DATA_W'(ra_f);
      shamt = int'(ra_f) % DATA_W;
      slt   = $signed(opa_q) < $signed(opb_q);
      case (op)
         OP_ADD:  {alu_c, alu_y} = {1'b0, opa_q} + {1'b0, opb_q};
         OP_SUB:  begin alu_y = opa_q - opb_q; alu_c = (opa_q < opb_q); end
         OP_AND:  alu_y = opa_q & opb_q;
         OP_OR:   alu_y = opa_q | opb_q;
         OP_XOR:  alu_y = opa_q ^ opb_q;
         OP_SLT:  alu_y = {{(DATA_W-1){1'b0}}, slt};
         OP_ADDI: {alu_c, alu_y} = {1'b0, opb_q} + {1'b0, imm};
         OP_SUBI: begin alu_y = opb_q - imm; alu_c = (opb_q < imm); end
         OP_ANDI: alu_y = opb_q & imm;
         OP_ORI:  alu_y = opb_q | imm;
         OP_SHLI: alu_y = opb_q << shamt;
         OP_SHRI: alu_y = opb_q >> shamt;
         OP_LI:   alu_y = DATA_W'({ra_f, rb_f});
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr_q    <= '0;
         opa_q      <= '0;
         opb_q      <= '0;
         alu_q      <= '0;
         carry_q    <= 1'b0;
         ill_q      <= 1'b0;
         result     <= '0;
         flag_zero  <= 1'b0;
         flag_carry <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (instr_valid) instr_q <= instr;
            DEC: begin
               opa_q <= rd_a;
               opb_q <= rd_b;
            end
            EXE: begin
               // An illegal op carries a zero result into WB.
               alu_q   <= ill ? '0 : alu_y;
               carry_q <= alu_c & ~ill;
               ill_q   <= ill;
            end
            WB: begin
               result <= alu_q;
               if (!ill_q) begin
                  flag_zero  <= (alu_q == '0);
                  flag_carry <= carry_q;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_nucleo_multiciclo.sv
module tb_nucleo_multiciclo;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, instr_valid, instr_ready, result_valid, illegal;
   logic        flag_zero, flag_carry, busy;
   logic [15:0] instr, result, dbg_data;
   logic [3:0]  dbg_addr;

   logic        v2, rdy2, rv2, ill2, fz2, fc2, busy2;
   logic [12:0] i2;
   logic [31:0] res2, dd2;
   logic [2:0]  da2;

   int checks = 0;
   int errors = 0;
   logic saw_ill;

   nucleo_multiciclo dut (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr(instr), .result(result), .result_valid(result_valid), .illegal(illegal),
      .flag_zero(flag_zero), .flag_carry(flag_carry), .busy(busy),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data));

   nucleo_multiciclo #(.DATA_W(32), .NUM_REGS(8)) dut32 (
      .clk(clk), .rst(rst), .instr_valid(v2), .instr_ready(rdy2),
      .instr(i2), .result(res2), .result_valid(rv2), .illegal(ill2),
      .flag_zero(fz2), .flag_carry(fc2), .busy(busy2),
      .dbg_addr(da2), .dbg_data(dd2));

   function automatic logic [15:0] enc(input int op, input int rc, input int ra, input int rb);
      return {op[3:0], rc[3:0], ra[3:0], rb[3:0]};
   endfunction

   function automatic logic [12:0] enc2(input int op, input int rc, input int ra, input int rb);
      return {op[3:0], rc[2:0], ra[2:0], rb[2:0]};
   endfunction

   // Called at a negedge with the core idle; returns at the negedge of cycle 4.
   task automatic issue(input logic [15:0] ins);
      bit seen;
      instr = ins;
      instr_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      instr_valid = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 8 && !seen; k++) begin
         if (result_valid) begin seen = 1'b1; saw_ill = illegal; end
         else @(negedge clk);
      end
      @(negedge clk);
      checks++;
      if (!seen) begin errors++; $display("FAIL issue_timeout instr=%h no result_valid", ins); end
   endtask

   task automatic issue2(input logic [12:0] ins);
      bit seen;
      i2 = ins;
      v2 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      v2 = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 8 && !seen; k++) begin
         if (rv2) seen = 1'b1;
         else @(negedge clk);
      end
      @(negedge clk);
      checks++;
      if (!seen) begin errors++; $display("FAIL issue2_timeout instr=%h no result_valid", ins); end
   endtask

   task automatic test_reset;
      rst = 1'b1; instr_valid = 1'b0; instr = '0; dbg_addr = 4'd1;
      v2 = 1'b0; i2 = '0; da2 = '0; saw_ill = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({instr_ready, busy, result_valid, illegal, flag_zero, flag_carry} !== 6'b100000) begin
         errors++;
         $display("FAIL reset_ctrl got %b want 100000",
                  {instr_ready, busy, result_valid, illegal, flag_zero, flag_carry});
      end
      checks++;
      if (result !== 16'h0 || dbg_data !== 16'h0) begin
         errors++; $display("FAIL reset_data result=%h dbg=%h want 0 0", result, dbg_data);
      end
   endtask

   task automatic test_li_timing;
      dbg_addr = 4'd1;
      instr = enc(12, 1, 3, 12);
      instr_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      // Offered while busy: must be ignored.
      instr = enc(12, 9, 7, 7);
      for (int c = 1; c <= 2; c++) begin
         checks++;
         if ({instr_ready, busy, result_valid} !== 3'b010) begin
            errors++; $display("FAIL li_cycle%0d got %b want 010", c, {instr_ready, busy, result_valid});
         end
         @(negedge clk);
      end
      checks++;
      if ({instr_ready, busy, result_valid, illegal} !== 4'b0110 || dbg_data !== 16'h0) begin
         errors++;
         $display("FAIL li_cycle3 ctrl=%b dbg=%h want 0110 0000",
                  {instr_ready, busy, result_valid, illegal}, dbg_data);
      end
      instr_valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({instr_ready, busy, result_valid} !== 3'b100 || dbg_data !== 16'h003C || result !== 16'h003C) begin
         errors++;
         $display("FAIL li_cycle4 ctrl=%b dbg=%h result=%h want 100 003c 003c",
                  {instr_ready, busy, result_valid}, dbg_data, result);
      end
      dbg_addr = 4'd9;
      #1;
      checks++;
      if (dbg_data !== 16'h0) begin errors++; $display("FAIL busy_ignore R9=%h want 0000", dbg_data); end
      @(negedge clk);
   endtask

   task automatic test_add_carry;
      issue(enc(12, 2, 0, 1));   // R2 = 1
      issue(enc(1, 1, 0, 2));    // R1 = 0 - 1
      checks++;
      if (result !== 16'hFFFF || flag_carry !== 1'b1) begin
         errors++; $display("FAIL sub_r0 result=%h c=%b want ffff 1", result, flag_carry);
      end
      issue(enc(12, 3, 7, 7));   // R3 = 0x77
      issue(enc(0, 3, 1, 2));    // R3 = FFFF + 1
      dbg_addr = 4'd3;
      #1;
      checks++;
      if (dbg_data !== 16'h0 || result !== 16'h0 || {flag_zero, flag_carry} !== 2'b11) begin
         errors++;
         $display("FAIL add_carry R3=%h result=%h zc=%b want 0000 0000 11",
                  dbg_data, result, {flag_zero, flag_carry});
      end
   endtask

   task automatic test_sub_slt;
      issue(enc(12, 1, 0, 1));
      issue(enc(12, 2, 0, 2));
      issue(enc(1, 3, 1, 2));    // 1 - 2
      dbg_addr = 4'd3;
      #1;
      checks++;
      if (dbg_data !== 16'hFFFF || {flag_zero, flag_carry} !== 2'b01) begin
         errors++; $display("FAIL sub_borrow R3=%h zc=%b want ffff 01", dbg_data, {flag_zero, flag_carry});
      end
      issue(enc(5, 4, 3, 1));    // -1 < 1 signed
      dbg_addr = 4'd4;
      #1;
      checks++;
      if (dbg_data !== 16'h1 || result !== 16'h1 || {flag_zero, flag_carry} !== 2'b00) begin
         errors++;
         $display("FAIL slt R4=%h result=%h zc=%b want 0001 0001 00", dbg_data, result, {flag_zero, flag_carry});
      end
   endtask

   task automatic test_r0;
      issue(enc(12, 0, 5, 5));
      dbg_addr = 4'd0;
      #1;
      checks++;
      if (dbg_data !== 16'h0 || result !== 16'h0055 || flag_zero !== 1'b0) begin
         errors++; $display("FAIL r0_write R0=%h result=%h z=%b want 0000 0055 0", dbg_data, result, flag_zero);
      end
   endtask

   task automatic test_illegal;
      issue(enc(12, 5, 1, 2));   // R5 = 0x12, flags 00
      issue(enc(14, 5, 3, 3));
      dbg_addr = 4'd5;
      #1;
      checks++;
      if (saw_ill !== 1'b1 || result !== 16'h0 || {flag_zero, flag_carry} !== 2'b00 || dbg_data !== 16'h0012) begin
         errors++;
         $display("FAIL illegal_a ill=%b result=%h zc=%b R5=%h want 1 0000 00 0012",
                  saw_ill, result, {flag_zero, flag_carry}, dbg_data);
      end
      issue(enc(1, 1, 0, 2));    // R1 = 0 - 2 = FFFE
      issue(enc(0, 3, 1, 2));    // FFFE + 2 -> 0, carry
      checks++;
      if (saw_ill !== 1'b0 || {flag_zero, flag_carry} !== 2'b11) begin
         errors++; $display("FAIL illegal_setup ill=%b zc=%b want 0 11", saw_ill, {flag_zero, flag_carry});
      end
      issue(enc(14, 1, 0, 0));
      dbg_addr = 4'd1;
      #1;
      checks++;
      if (saw_ill !== 1'b1 || {flag_zero, flag_carry} !== 2'b11 || dbg_data !== 16'hFFFE) begin
         errors++;
         $display("FAIL illegal_b ill=%b zc=%b R1=%h want 1 11 fffe", saw_ill, {flag_zero, flag_carry}, dbg_data);
      end
   endtask

   task automatic test_alu_ops;
      logic [15:0] t_ins [11];
      logic [16:0] t_exp [11];   // {carry, result}
      issue(enc(12, 1, 10, 5));  // R1 = 0xA5
      issue(enc(12, 2, 3, 12));  // R2 = 0x3C
      issue(enc(12, 6, 0, 3));   // R6 = 3
      t_ins = '{enc(0, 3, 1, 2), enc(2, 3, 1, 2), enc(3, 3, 1, 2), enc(4, 3, 1, 2),
                enc(6, 3, 15, 2), enc(7, 3, 15, 2), enc(7, 3, 5, 6), enc(8, 3, 6, 1),
                enc(9, 3, 10, 1), enc(11, 3, 3, 1), enc(10, 3, 4, 1)};
      t_exp = '{17'h000E1, 17'h00024, 17'h000BD, 17'h00099,
                17'h0004B, 17'h0002D, 17'h1FFFE, 17'h00004,
                17'h000AF, 17'h00014, 17'h00A50};
      dbg_addr = 4'd3;
      for (int n = 0; n < 11; n++) begin
         issue(t_ins[n]);
         checks++;
         if ({flag_carry, result} !== t_exp[n] || dbg_data !== t_exp[n][15:0]) begin
            errors++;
            $display("FAIL alu_op%0d instr=%h got c=%b r=%h R3=%h want %h",
                     n, t_ins[n], flag_carry, result, dbg_data, t_exp[n]);
         end
      end
   endtask

   task automatic test_back_to_back;
      issue(enc(12, 1, 1, 0));   // R1 = 0x10
      checks++;
      if (instr_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b want 1", instr_ready); end
      issue(enc(0, 2, 1, 1));    // R2 = R1 + R1
      dbg_addr = 4'd2;
      #1;
      checks++;
      if (dbg_data !== 16'h0020 || result !== 16'h0020) begin
         errors++; $display("FAIL b2b_dep R2=%h result=%h want 0020 0020", dbg_data, result);
      end
   endtask

   task automatic test_reset_mid;
      bit seen;
      instr = enc(6, 8, 3, 0);   // ADDI R8 = R0 + 3
      instr_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      instr_valid = 1'b0;
      @(negedge clk);            // cycle 2
      rst = 1'b1;
      #1;
      checks++;
      if ({instr_ready, busy, result_valid} !== 3'b100) begin
         errors++; $display("FAIL rst_mid_ctrl got %b want 100", {instr_ready, busy, result_valid});
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (instr_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got %b want 1", instr_ready); end
      seen = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (result_valid) seen = 1'b1;
      end
      dbg_addr = 4'd8;
      #1;
      checks++;
      if (seen || dbg_data !== 16'h0 || result !== 16'h0) begin
         errors++; $display("FAIL rst_mid_drop rv_seen=%b R8=%h result=%h want 0 0000 0000", seen, dbg_data, result);
      end
      @(negedge clk);
   endtask

   task automatic test_wide;
      issue2(enc2(12, 1, 0, 1)); // R1 = 1
      issue2(enc2(10, 7, 5, 1)); // R7 = R1 << 5
      da2 = 3'd7;
      #1;
      checks++;
      if (dd2 !== 32'h20 || res2 !== 32'h20 || fc2 !== 1'b0) begin
         errors++; $display("FAIL wide_shli R7=%h result=%h c=%b want 00000020 00000020 0", dd2, res2, fc2);
      end
      @(negedge clk);
      issue2(enc2(1, 2, 0, 1));  // R2 = 0 - 1
      da2 = 3'd2;
      #1;
      checks++;
      if (dd2 !== 32'hFFFF_FFFF || fc2 !== 1'b1 || fz2 !== 1'b0) begin
         errors++; $display("FAIL wide_sub R2=%h c=%b z=%b want ffffffff 1 0", dd2, fc2, fz2);
      end
   endtask

   initial begin
      test_reset();
      test_li_timing();
      test_add_carry();
      @(negedge clk);
      test_sub_slt();
      @(negedge clk);
      test_r0();
      @(negedge clk);
      test_illegal();
      @(negedge clk);
      test_alu_ops();
      test_back_to_back();
      @(negedge clk);
      test_reset_mid();
      test_wide();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
